// File: rtl/sum_frame_rx.sv
// sum_frame_rx: receives SOF/LEN/payload/CHK frames, forwards the payload and checks the 8-bit sum.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready is the input byte stream;
// out_data/out_valid/out_ready/out_last is the payload stream; frame_ok/frame_err are
// one-cycle status pulses; err_code gives the abort cause; drop_cnt counts bytes discarded in IDLE.
module sum_frame_rx #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CHK} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_sum;
  logic [15:0] r_tmo;
  logic        w_acc;
  logic        w_stall;
  logic        w_tmo;
  logic        w_bad_len;
  logic [7:0]  w_sum;
  // DATA holds a single output register, so a new byte is taken only when it is free or draining
  assign in_ready  = !rst && (r_state != S_DATA || !out_valid || out_ready);
  assign w_acc     = in_valid && in_ready;
  // downstream backpressure with data waiting is not idleness
  assign w_stall   = r_state == S_DATA && in_valid && !in_ready;
  assign w_tmo     = r_state != S_IDLE && !w_acc && !w_stall && r_tmo == 16'(TIMEOUT - 1);
  assign w_bad_len = in_data == 8'h00 || in_data > 8'(MAX_LEN);
  assign w_sum     = r_sum + in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_tmo     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      drop_cnt  <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      r_tmo <= (r_state == S_IDLE || w_acc) ? '0 : w_stall ? r_tmo : r_tmo + 16'd1;
      if (w_tmo) begin
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        r_state   <= S_IDLE;
      end else if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            if (in_data == 8'hA5) r_state <= S_LEN;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end
          S_LEN: begin
            if (w_bad_len) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
              r_state   <= S_IDLE;
            end else begin
              r_cnt   <= in_data;
              r_sum   <= in_data;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= r_cnt == 8'd1;
            r_sum     <= w_sum;
            r_cnt     <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) r_state <= S_CHK;
          end
          S_CHK: begin
            r_state <= S_IDLE;
            if (w_sum == 8'h00) frame_ok <= 1'b1;
            else begin
              frame_err <= 1'b1;
              err_code  <= 2'b10;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/sum_frame_rx.md
SUM_FRAME_RX -- requirements
Module: sum_frame_rx

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum accepted payload length in bytes, legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255: number of idle cycles allowed mid-frame before the frame is aborted, legal range 1..65535.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all logic.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_data  input  8  incoming byte stream.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_data  output  8  forwarded payload byte.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_last  output  1  out_data is the final payload byte of the frame.
REQ-013 frame_ok  output  1  one-cycle pulse: frame checksum correct.
REQ-014 frame_err  output  1  one-cycle pulse: frame aborted or checksum wrong.
REQ-015 err_code  output  2  cause, valid with frame_err: 01 bad length, 10 bad checksum, 11 timeout.
REQ-016 drop_cnt  output  8  saturating count of non-SOF bytes discarded in IDLE.

Function
REQ-017 Frame format: SOF byte 0xA5, LEN byte, LEN payload bytes, CHK byte; the frame is good when (LEN + all payload + CHK) mod 256 == 0.
REQ-018 A byte is transferred only in a cycle with in_valid && in_ready; out transfers only on out_valid && out_ready.
REQ-019 States: IDLE, LEN, DATA, CHK; reset state IDLE.
REQ-020 IDLE: in_ready=1; 0xA5 -> LEN; any other byte is discarded and increments drop_cnt, which saturates at 255.
REQ-021 LEN: in_ready=1; LEN 0 or LEN > MAX_LEN -> frame_err with err_code 01, then IDLE; otherwise load the byte counter, seed the 8-bit sum with LEN, and go to DATA.
REQ-022 DATA: in_ready = !out_valid || out_ready (single output register); each accepted byte is added mod 256 to the sum and loaded into out_data.
REQ-023 DATA: out_valid is set the cycle after acceptance (latency 1) and held with out_data stable until out_ready.
REQ-024 DATA: out_last=1 with the LENth byte; after that byte the FSM goes to CHK.
REQ-025 CHK: in_ready=1; on acceptance, if (sum + CHK) mod 256 == 0 then frame_ok pulses the next cycle, else frame_err pulses the next cycle with err_code 10; then IDLE.
REQ-026 Timeout counter: cleared on every accepted byte and in IDLE; counts cycles in LEN/DATA/CHK without an accepted byte; on reaching TIMEOUT -> frame_err with err_code 11, then IDLE.
REQ-027 Cycles stalled by out_ready=0 while in_valid=1 in DATA SHALL NOT count toward timeout.
REQ-028 A byte 0xA5 inside LEN/DATA/CHK is treated as ordinary data, not as a resync.
REQ-029 On abort (bad length or timeout), a pending out_valid byte is still delivered, out_last is not asserted for the aborted frame, and no frame_ok follows.
REQ-030 frame_ok and frame_err are never high together; each pulse lasts exactly one cycle; err_code holds its last value otherwise.
REQ-031 The CHK-to-IDLE transition completes so that an SOF presented the cycle after CHK acceptance is accepted (back-to-back frames, no gap cycle).

Reset
REQ-032 While rst=1: state IDLE; out_valid, out_last, frame_ok, frame_err = 0; err_code = 00; drop_cnt = 0; sum, byte counter and timeout counter = 0; in_ready = 0.
REQ-033 Reset asserted mid-frame discards the frame silently, with no status pulse; the first cycle after release is IDLE with in_ready=1.

Verification
REQ-034 Good frame: A5 03 10 20 30 9D, out_ready=1 -> out 10,20,30, out_last on 30, frame_ok one cycle after 9D is accepted, frame_err never asserted.
REQ-035 Bad checksum: A5 02 01 02 00 -> out 01,02, frame_err with err_code 10, no frame_ok.
REQ-036 Bad length: A5 00 and, with MAX_LEN=16, A5 11 -> frame_err with err_code 01 each time; the next byte is handled in IDLE.
REQ-037 Backpressure: good frame with out_ready toggling 1/0 -> no data lost or duplicated, out_data stable while stalled, no timeout, frame_ok.
REQ-038 Timeout and drops: with TIMEOUT=8, send 00 FF then A5 02 11 and go idle 8 cycles -> drop_cnt=2, out 11, frame_err with err_code 11; reset asserted mid-frame -> no pulse and drop_cnt=0.
